// File: rtl/instruction_memory.sv
// instruction_memory
// Read-only 64-word program store for the IF stage. A byte address from the
// PC selects a word (addr[7:2]); the selected word is registered, so it is
// visible on I one clock after the address is sampled. Addresses at or above
// 256 return a NOP. Synchronous active-high reset loads a NOP.
//
// Interface timing: there is no handshake. A new address is accepted on
// every rising edge, and I is valid for exactly that address after the edge.
// I holds its value between edges.
module instruction_memory (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    output logic [31:0] I
);

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic [5:0]  w_word_idx;
    logic        w_in_range;
    logic [31:0] w_rom_word;
    logic [31:0] w_next_instr;
    logic [1:0]  w_unused_addr_lo;
    logic [31:0] r_instr;

    // Byte offset within a word does not matter: misaligned reads return the
    // containing word.
    assign w_unused_addr_lo = addr[1:0];
    assign w_word_idx       = addr[7:2];
    assign w_in_range       = (addr[31:8] == 24'd0);

    // Fixed program contents; every word past the eighth is a NOP.
    always_comb begin
        w_rom_word = NOP;
        case (w_word_idx)
            6'd0:    w_rom_word = 32'h0022_1820; // add $3,$1,$2
            6'd1:    w_rom_word = 32'h0061_2022; // sub $4,$3,$1
            6'd2:    w_rom_word = 32'h0064_2824; // and $5,$3,$4
            6'd3:    w_rom_word = 32'h00A2_3025; // or  $6,$5,$2
            6'd4:    w_rom_word = 32'h8C07_0004; // lw  $7,4($0)
            6'd5:    w_rom_word = 32'hAC07_0008; // sw  $7,8($0)
            6'd6:    w_rom_word = 32'h0022_402A; // slt $8,$1,$2
            6'd7:    w_rom_word = 32'h0800_0000; // j   0
            default: w_rom_word = NOP;
        endcase
    end

    // Out-of-range addresses fetch a NOP rather than aliasing into the ROM.
    always_comb begin
        w_next_instr = NOP;
        if (w_in_range) begin
            w_next_instr = w_rom_word;
        end
    end

    // Output register; reset takes priority over the address.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr <= NOP;
        end else begin
            r_instr <= w_next_instr;
        end
    end

    assign I = r_instr;

endmodule

// File: tb/tb_instruction_memory.sv
// Testbench for instruction_memory: directed vector table, hand-written
// hold / mid-cycle sequences, and randomized fetches scored against a
// behavioural model of the program store.
module tb_instruction_memory;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] I;

    int n_pass;
    int n_total;

    logic [31:0] exp_q[$];

    instruction_memory dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .I     (I)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    // The program as a plain list; anything outside it reads as zero.
    function automatic logic [31:0] ref_fetch(input logic rst, input logic [31:0] a);
        logic [31:0] prog [8];
        int unsigned idx;
        prog[0] = 32'h00221820;
        prog[1] = 32'h00612022;
        prog[2] = 32'h00642824;
        prog[3] = 32'h00A23025;
        prog[4] = 32'h8C070004;
        prog[5] = 32'hAC070008;
        prog[6] = 32'h0022402A;
        prog[7] = 32'h08000000;
        if (rst) return 32'h0;
        if (a >= 32'd256) return 32'h0;
        idx = a / 4;
        if (idx < 8) return prog[idx];
        return 32'h0;
    endfunction

    // ---------------- driver / checker tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Drive inputs away from the edge, let one rising edge happen, settle.
    task automatic drive_cycle(input logic r, input logic [31:0] a);
        @(negedge clk);
        reset = r;
        addr  = a;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string       name;
        logic        rst;
        logic [31:0] a;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [32];
    int   n_vec;

    task automatic add_vec(input string nm, input logic r, input logic [31:0] a, input logic [31:0] e);
        vecs[n_vec].name = nm;
        vecs[n_vec].rst  = r;
        vecs[n_vec].a    = a;
        vecs[n_vec].exp  = e;
        n_vec++;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] ra;
        logic        rr;
        logic [31:0] e;

        n_pass  = 0;
        n_total = 0;
        n_vec   = 0;
        reset   = 1'b1;
        addr    = 32'd4;

        add_vec("reset_0",      1'b1, 32'd4,        32'h00000000);
        add_vec("reset_1",      1'b1, 32'd4,        32'h00000000);
        add_vec("release_a0",   1'b0, 32'd0,        32'h00221820);
        add_vec("seq_a4",       1'b0, 32'd4,        32'h00612022);
        add_vec("seq_a8",       1'b0, 32'd8,        32'h00642824);
        add_vec("seq_a12",      1'b0, 32'd12,       32'h00A23025);
        add_vec("seq_a16",      1'b0, 32'd16,       32'h8C070004);
        add_vec("seq_a20",      1'b0, 32'd20,       32'hAC070008);
        add_vec("seq_a24",      1'b0, 32'd24,       32'h0022402A);
        add_vec("seq_a28",      1'b0, 32'd28,       32'h08000000);
        add_vec("mis_a5",       1'b0, 32'd5,        32'h00612022);
        add_vec("mis_a6",       1'b0, 32'd6,        32'h00612022);
        add_vec("mis_a7",       1'b0, 32'd7,        32'h00612022);
        add_vec("mis_a30",      1'b0, 32'd30,       32'h08000000);
        add_vec("unused_a32",   1'b0, 32'd32,       32'h00000000);
        add_vec("unused_a252",  1'b0, 32'd252,      32'h00000000);
        add_vec("oor_a256",     1'b0, 32'd256,      32'h00000000);
        add_vec("oor_fffffffc", 1'b0, 32'hFFFFFFFC, 32'h00000000);
        add_vec("oor_a260",     1'b0, 32'd260,      32'h00000000);
        add_vec("mid_a0",       1'b0, 32'd0,        32'h00221820);
        add_vec("mid_a4",       1'b0, 32'd4,        32'h00612022);
        add_vec("mid_a8",       1'b0, 32'd8,        32'h00642824);
        add_vec("mid_rst_a12",  1'b1, 32'd12,       32'h00000000);
        add_vec("mid_after_a16",1'b0, 32'd16,       32'h8C070004);

        for (int i = 0; i < n_vec; i++) begin
            drive_cycle(vecs[i].rst, vecs[i].a);
            check(vecs[i].name, I, vecs[i].exp);
        end

        // Hold: addr=16 for 1000 cycles, output never moves.
        for (int i = 0; i < 1000; i++) begin
            drive_cycle(1'b0, 32'd16);
            check("hold_a16", I, 32'h8C070004);
        end

        // Mid-cycle address change has no effect until the next edge.
        drive_cycle(1'b0, 32'd20);
        check("midcyc_before", I, 32'hAC070008);
        #2 addr = 32'd0;
        #1 check("midcyc_hold", I, 32'hAC070008);
        @(posedge clk);
        #1 check("midcyc_next_edge", I, 32'h00221820);

        // Randomized fetches scored through the expected queue.
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0:       ra = $urandom_range(0, 31);
                1:       ra = $urandom_range(0, 255);
                2:       ra = $urandom_range(256, 1023);
                default: ra = $urandom;
            endcase
            rr = ($urandom_range(0, 7) == 0);
            exp_q.push_back(ref_fetch(rr, ra));
            drive_cycle(rr, ra);
            e = exp_q.pop_front();
            check("random_fetch", I, e);
        end

        // ---------------- final report ----------------
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
